sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Shares the single SDRAM controller between four burst ports: two write ports (input FIFOs to SDRAM) and two read ports (SDRAM to output FIFOs). It issues one burst request at a time and drives the controller's request, burst-length and address inputs. It routes the controller's per-word acks back to the granted port as data strobes. It keeps a per-port linear address that wraps inside a programmable frame region. It sits between the capture/LCD-resize FIFOs and the SDRAM controller.

## Interface
Parameters:
- ADDR_W, 24, SDRAM word address width ({bank,row,col}).
- BURST_LEN, 10'd256, words per burst; valid range 1-256.

Ports (port index: 0=wr0, 1=wr1, 2=rd0, 3=rd1):
- clk  in  1  system clock, same clock as the SDRAM controller.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- sdram_init_done  in  1  controller initialisation complete.
- port_ready  in  4  wr ports: FIFO holds at least BURST_LEN words; rd ports: FIFO has room for at least BURST_LEN words.
- frame_start  in  4  one-cycle pulse; restarts that port's address at its base.
- port_base  in  4*ADDR_W  region base per port; port i occupies bits [i*ADDR_W +: ADDR_W].
- port_len  in  4*ADDR_W  region length in words per port; must be a nonzero multiple of BURST_LEN.
- sdram_wr_req  out  1  write burst request to the controller.
- sdram_rd_req  out  1  read burst request to the controller.
- sdram_wr_ack  in  1  controller write ack; high once per word accepted.
- sdram_rd_ack  in  1  controller read ack; high once per valid read word.
- sdram_wr_burst  out  10  constant BURST_LEN.
- sdram_rd_burst  out  10  constant BURST_LEN.
- sdram_addr  out  ADDR_W  burst start address of the granted port.
- port_grant  out  4  one-hot grant; all zero when idle.
- port_strobe  out  4  wr ports: pop one word from the FIFO; rd ports: push one word into the FIFO.
- burst_err  out  1  sticky flag: a burst ended with an ack count different from BURST_LEN.

## Operation
- FSM states: ARB_IDLE, ARB_REQ, ARB_XFER, ARB_DONE.
- ARB_IDLE: stays here while sdram_init_done=0 or no port_ready bit is set.
  - Otherwise registers the winner into port_grant and loads sdram_addr from that port's address.
  - Asserts sdram_wr_req (ports 0/1) or sdram_rd_req (ports 2/3), then moves to ARB_REQ.
- ARB_REQ: holds the request until the matching ack is first seen high.
  - On that cycle: drops the request, sets the word count to 1, moves to ARB_XFER.
- ARB_XFER: counts ack-high cycles while ack stays high.
  - When ack is seen low, moves to ARB_DONE.
- ARB_DONE, one cycle:
  - Sets burst_err if the word count differs from BURST_LEN.
  - Advances the port address: next = addr + BURST_LEN; if next >= base + len, next = base. Compute the sum ADDR_W+1 bits wide.
  - Updates the priority pointer, clears port_grant, returns to ARB_IDLE.
- port_strobe[i] = port_grant[i] & matching ack, combinational. A strobe is never issued for a port that is not granted.
- frame_start[i]:
  - Port not granted: address loads port_base[i] on the next cycle.
  - Port granted: the restart is held pending and applied in ARB_DONE instead of the increment.
- Simultaneous frame_start and ARB_DONE on the same port: the restart wins.
- After reset every port address equals its port_base; addresses reload from port_base every cycle until the port's first grant or frame_start.
- Reset mid-burst returns the FSM to ARB_IDLE. Any remaining controller acks produce no strobes, because port_grant is 0.

## Timing
- Reset values: all requests 0, port_grant 0, port_strobe 0, sdram_addr 0, burst_err 0. sdram_*_burst always equal BURST_LEN.
- Latency from port_ready high in ARB_IDLE to request high: 1 cycle. sdram_addr and port_grant are valid on the same edge as the request.
- Request falls on the cycle after the first ack is sampled.
- Minimum gap between bursts: ARB_DONE + ARB_IDLE = 2 cycles after ack falls.
- port_ready is sampled only in ARB_IDLE; deasserting it mid-burst has no effect.

## Configuration
- Macro SDRAM_ARB_RR_EN.
- Defined: round-robin. The search starts at the port after the last granted port (ring 0->1->2->3->0); the pointer resets to port 0.
- Undefined: fixed priority wr0 > wr1 > rd0 > rd1; the pointer logic is removed.

## Test plan
- Reset, init_done=1, port_ready=4'b0001, base0=0, len0=512, controller model acking 256 cycles -> wr_req high 1 cycle after ready, 256 strobes on port 0, next burst at addr 256, third burst at addr 0 (wrap).
- All four port_ready=1 continuously, SDRAM_ARB_RR_EN defined -> grant order 0,1,2,3,0; undefined -> port 0 granted every burst.
- frame_start[2] pulsed mid-burst on rd0 (base 0x1000, addr 0x1100) -> the following rd0 burst starts at 0x1000, not 0x1200.
- Controller model acks only 255 cycles -> burst_err=1 after ARB_DONE and stays 1 until reset.
- rst_n low for 1 cycle at ack word 100 -> FSM in ARB_IDLE, no further strobes, all addresses equal their port_base.
- sdram_init_done=0 with all ports ready -> no request for 1000 cycles; first request 1 cycle after init_done rises.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - four-port burst arbiter in front of the SDRAM controller
//
// Shares one SDRAM controller between two write ports (0, 1) and two read
// ports (2, 3). It issues one burst at a time and routes the controller's
// per-word acks back to the granted port as FIFO strobes. It keeps a linear
// address per port that wraps inside that port's frame region.
//
// Optional feature macro: SDRAM_ARB_RR_EN
//   defined   - round-robin arbitration starting after the last granted port
//   undefined - fixed priority wr0 > wr1 > rd0 > rd1
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   sdram_init_done   controller initialisation complete
//   port_ready[3:0]   port can take or give a full burst
//   frame_start[3:0]  one-cycle pulse: restart that port at its base
//   port_base/len     per-port region base and length, ADDR_W bits per port
//   sdram_wr/rd_req   burst requests to the controller
//   sdram_wr/rd_ack   per-word acks from the controller
//   sdram_wr/rd_burst constant burst length
//   sdram_addr        burst start address of the granted port
//   port_grant[3:0]   one-hot grant, zero when idle
//   port_strobe[3:0]  per-word pop (write ports) / push (read ports)
//   burst_err         sticky: a burst ended with the wrong word count

module sdram_port_arbiter #(
  parameter int         ADDR_W    = 24,
  parameter logic [9:0] BURST_LEN = 10'd256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sdram_init_done,
  input  logic [3:0]          port_ready,
  input  logic [3:0]          frame_start,
  input  logic [4*ADDR_W-1:0] port_base,
  input  logic [4*ADDR_W-1:0] port_len,
  output logic                sdram_wr_req,
  output logic                sdram_rd_req,
  input  logic                sdram_wr_ack,
  input  logic                sdram_rd_ack,
  output logic [9:0]          sdram_wr_burst,
  output logic [9:0]          sdram_rd_burst,
  output logic [ADDR_W-1:0]   sdram_addr,
  output logic [3:0]          port_grant,
  output logic [3:0]          port_strobe,
  output logic                burst_err
);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_XFER,
    ARB_DONE
  } arb_state_t;

  localparam logic [ADDR_W:0] BURST_EXT = (ADDR_W+1)'(BURST_LEN);

  arb_state_t        state;
  logic [1:0]        cur_port;
  logic [9:0]        word_cnt;
  logic [ADDR_W-1:0] port_addr [4];
  logic [ADDR_W-1:0] base_w [4];
  logic [ADDR_W-1:0] len_w [4];
  logic [3:0]        started;
  logic [3:0]        restart_pend;

  logic              cur_ack;
  logic              win_valid;
  logic [1:0]        win_idx;
  logic [1:0]        cand_idx;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W:0]   addr_lim;
  logic [ADDR_W-1:0] addr_next;

`ifdef SDRAM_ARB_RR_EN
  logic [1:0]        rr_ptr;
`endif

  assign sdram_wr_burst = BURST_LEN;
  assign sdram_rd_burst = BURST_LEN;

  // Strobes come straight from the controller ack, gated by the registered
  // grant, so an ack arriving after a reset or outside a burst never strobes.
  assign port_strobe = port_grant & {sdram_rd_ack, sdram_rd_ack, sdram_wr_ack, sdram_wr_ack};

  // Port index bit 1 separates the read ports from the write ports.
  assign cur_ack = cur_port[1] ? sdram_rd_ack : sdram_wr_ack;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      base_w[i] = port_base[i*ADDR_W +: ADDR_W];
      len_w[i]  = port_len[i*ADDR_W +: ADDR_W];
    end
  end

  // Winner search. The loop runs from the lowest-priority candidate to the
  // highest so that the last match seen is the one that wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand_idx  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
`ifdef SDRAM_ARB_RR_EN
      cand_idx = rr_ptr + 2'(k);
`else
      cand_idx = 2'(k);
`endif
      if (port_ready[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // The sum is one bit wider than the address so that a region ending at the
  // top of the address space still wraps correctly.
  always_comb begin
    addr_sum  = {1'b0, port_addr[cur_port]} + BURST_EXT;
    addr_lim  = {1'b0, base_w[cur_port]} + {1'b0, len_w[cur_port]};
    addr_next = (addr_sum >= addr_lim) ? base_w[cur_port] : addr_sum[ADDR_W-1:0];
  end

  // Per-port address tracking. Until a port has been granted or restarted it
  // follows port_base every cycle, so software can program the base late.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        port_addr[i] <= base_w[i];
      end
      started      <= 4'b0000;
      restart_pend <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (port_grant[i]) begin
          if (state == ARB_DONE) begin
            // A restart requested during the burst, or on this very cycle,
            // takes the place of the normal increment.
            restart_pend[i] <= 1'b0;
            port_addr[i]    <= (restart_pend[i] || frame_start[i]) ? base_w[i] : addr_next;
          end else if (frame_start[i]) begin
            restart_pend[i] <= 1'b1;
          end
        end else if (frame_start[i] || !started[i]) begin
          port_addr[i] <= base_w[i];
          if (frame_start[i]) begin
            started[i] <= 1'b1;
          end
        end
      end
      if (state == ARB_IDLE && sdram_init_done && win_valid) begin
        started[win_idx] <= 1'b1;
      end
    end
  end

  // Burst sequencing FSM with registered request/grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      cur_port     <= 2'd0;
      word_cnt     <= 10'd0;
      port_grant   <= 4'b0000;
      sdram_wr_req <= 1'b0;
      sdram_rd_req <= 1'b0;
      sdram_addr   <= '0;
      burst_err    <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      rr_ptr       <= 2'd0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (sdram_init_done && win_valid) begin
            port_grant   <= 4'b0001 << win_idx;
            cur_port     <= win_idx;
            // A restart on the grant cycle is honoured for this burst too.
            sdram_addr   <= frame_start[win_idx] ? base_w[win_idx] : port_addr[win_idx];
            sdram_wr_req <= ~win_idx[1];
            sdram_rd_req <= win_idx[1];
            state        <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (cur_ack) begin
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            word_cnt     <= 10'd1;
            state        <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (cur_ack) begin
            // Saturate so a runaway controller cannot wrap back to a match.
            if (word_cnt != 10'h3ff) begin
              word_cnt <= word_cnt + 10'd1;
            end
          end else begin
            state <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          if (word_cnt != BURST_LEN) begin
            burst_err <= 1'b1;
          end
`ifdef SDRAM_ARB_RR_EN
          rr_ptr     <= cur_port + 2'd1;
`endif
          port_grant <= 4'b0000;
          state      <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter

module tb_sdram_port_arbiter;

  localparam int ADDR_W = 24;
  localparam int BL     = 256;

  logic                clk;
  logic                rst_n;
  logic                sdram_init_done;
  logic [3:0]          port_ready;
  logic [3:0]          frame_start;
  logic [4*ADDR_W-1:0] port_base;
  logic [4*ADDR_W-1:0] port_len;
  logic                sdram_wr_req;
  logic                sdram_rd_req;
  logic                sdram_wr_ack;
  logic                sdram_rd_ack;
  logic [9:0]          sdram_wr_burst;
  logic [9:0]          sdram_rd_burst;
  logic [ADDR_W-1:0]   sdram_addr;
  logic [3:0]          port_grant;
  logic [3:0]          port_strobe;
  logic                burst_err;

  sdram_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (10'd256)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .port_ready      (port_ready),
    .frame_start     (frame_start),
    .port_base       (port_base),
    .port_len        (port_len),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_wr_burst  (sdram_wr_burst),
    .sdram_rd_burst  (sdram_rd_burst),
    .sdram_addr      (sdram_addr),
    .port_grant      (port_grant),
    .port_strobe     (port_strobe),
    .burst_err       (burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass;
  int   n_checks;
  int   n_fail;

  // Reference model: region per port, expected next burst address, the
  // round-robin search start and the sticky error flag.
  int   m_base [4];
  int   m_len  [4];
  int   m_addr [4];
  int   m_ptr;
  logic m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] rdy);
`ifdef SDRAM_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      if (rdy[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (rdy[k]) return k;
    end
`endif
    return -1;
  endfunction

  // Controller model: waits for the request, acks n words back to back,
  // optionally pulses frame_start or reset at a given ack word index.
  task automatic run_burst(input int n, input int p, input int fs_at, input int rst_at);
    int         waited;
    int         strobes;
    int         bad;
    logic [3:0] mask;
    logic [3:0] exp_s;
    logic       is_wr;
    mask   = 4'(1 << p);
    is_wr  = (p < 2);
    waited = 0;
    @(negedge clk);
    while (!(sdram_wr_req || sdram_rd_req) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("req_seen", 32'(sdram_wr_req | sdram_rd_req), 32'd1);
    if (!(sdram_wr_req || sdram_rd_req)) return;
    check("grant", 32'(port_grant), 32'(mask));
    check("addr", 32'(sdram_addr), 32'(m_addr[p]));
    check("req_kind", {30'd0, sdram_wr_req, sdram_rd_req}, {30'd0, is_wr, !is_wr});
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("req_hold", 32'(sdram_wr_req | sdram_rd_req), 32'd1);
    strobes = 0;
    bad     = 0;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      if (is_wr) sdram_wr_ack = 1'b1;
      else       sdram_rd_ack = 1'b1;
      frame_start = (j == fs_at) ? mask : 4'b0000;
      if (j == rst_at) begin
        rst_n      = 1'b0;
        port_ready = 4'b0000;
      end else begin
        rst_n = 1'b1;
      end
      @(negedge clk);
      exp_s = (rst_at >= 0 && j > rst_at) ? 4'b0000 : mask;
      if (port_strobe !== exp_s) bad++;
      if (port_strobe[p]) strobes++;
      if (j == 1) check("req_drop", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
    end
    @(posedge clk);
    #1;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    frame_start  = 4'b0000;
    rst_n        = 1'b1;
    check("strobe_count", 32'(strobes), 32'((rst_at >= 0) ? rst_at + 1 : n));
    check("strobe_pattern", 32'(bad), 32'd0);
    if (rst_at >= 0) begin
      for (int i = 0; i < 4; i++) m_addr[i] = m_base[i];
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      if (fs_at >= 0) m_addr[p] = m_base[p];
      else            m_addr[p] = m_base[p] + ((m_addr[p] - m_base[p] + BL) % m_len[p]);
      m_ptr = (p + 1) % 4;
      if (n != BL) m_err = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("grant_clear", 32'(port_grant), 32'd0);
    check("burst_err", 32'(burst_err), 32'(m_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int p;
    n_pass   = 0;
    n_checks = 0;
    n_fail   = 0;

    m_base[0] = 0;
    m_len[0]  = 512;
    m_base[1] = 32'h4000 + $urandom_range(0, 255);
    m_len[1]  = BL * $urandom_range(1, 4);
    m_base[2] = 32'h1000;
    m_len[2]  = 32'h400;
    m_base[3] = 32'h8000 + $urandom_range(0, 4095);
    m_len[3]  = BL * $urandom_range(2, 3);
    for (int i = 0; i < 4; i++) begin
      port_base[i*ADDR_W +: ADDR_W] = m_base[i][ADDR_W-1:0];
      port_len[i*ADDR_W +: ADDR_W]  = m_len[i][ADDR_W-1:0];
      m_addr[i] = m_base[i];
    end
    m_ptr = 0;
    m_err = 1'b0;

    rst_n           = 1'b0;
    sdram_init_done = 1'b0;
    port_ready      = 4'b0000;
    frame_start     = 4'b0000;
    sdram_wr_ack    = 1'b0;
    sdram_rd_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values.
    @(negedge clk);
    check("rst_wr_req", 32'(sdram_wr_req), 32'd0);
    check("rst_rd_req", 32'(sdram_rd_req), 32'd0);
    check("rst_grant", 32'(port_grant), 32'd0);
    check("rst_strobe", 32'(port_strobe), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_err", 32'(burst_err), 32'd0);
    check("wr_burst", 32'(sdram_wr_burst), 32'(BL));
    check("rd_burst", 32'(sdram_rd_burst), 32'(BL));

    // No request while the controller is still initialising.
    port_ready = 4'b1111;
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sdram_wr_req || sdram_rd_req) cnt++;
    end
    check("no_req_before_init", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    sdram_init_done = 1'b1;
    @(negedge clk);
    check("init_req_not_yet", 32'(sdram_wr_req | sdram_rd_req), 32'd0);
    @(negedge clk);
    check("init_req_1cyc", 32'(sdram_wr_req | sdram_rd_req), 32'd1);
    p = model_winner(port_ready);
    port_ready = 4'b0000;
    run_burst(BL, p, -1, -1);

    // Single write port: one-cycle latency, then increment and wrap.
    @(posedge clk);
    #1;
    port_ready = 4'b0001;
    @(negedge clk);
    check("lat_req_not_yet", 32'(sdram_wr_req), 32'd0);
    @(negedge clk);
    check("lat_req_1cyc", 32'(sdram_wr_req), 32'd1);
    run_burst(BL, 0, -1, -1);
    run_burst(BL, 0, -1, -1);

    // All ports ready continuously.
    port_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      p = model_winner(port_ready);
      run_burst(BL, p, -1, -1);
    end

    // Random ready patterns.
    for (int k = 0; k < 4; k++) begin
      port_ready = 4'($urandom_range(1, 15));
      p = model_winner(port_ready);
      run_burst(BL, p, -1, -1);
    end

    // Restart of an idle port, then a restart held during a rd0 burst.
    port_ready = 4'b0000;
    @(posedge clk);
    #1;
    frame_start = 4'b0100;
    @(posedge clk);
    #1;
    frame_start = 4'b0000;
    m_addr[2] = m_base[2];
    port_ready = 4'b0100;
    run_burst(BL, 2, -1, -1);
    run_burst(BL, 2, 50, -1);
    run_burst(BL, 2, -1, -1);

    // Short burst sets the sticky error; a good burst leaves it set.
    port_ready = 4'b0001;
    run_burst(BL - 1, 0, -1, -1);
    run_burst(BL, 0, -1, -1);

    // Reset at ack word 100, then every port restarts at its base.
    port_ready = 4'b0010;
    run_burst(BL, 1, -1, 100);
    for (int i = 0; i < 4; i++) begin
      port_ready = 4'(1 << i);
      p = model_winner(port_ready);
      run_burst(BL, p, -1, -1);
    end
    port_ready = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
